// File: rtl/board_entry.sv
// rtl/board_entry.sv - front-panel switch/button entry into register file or data memory (option: BOARD_ENTRY_AUTO_INC_EN)
module board_entry #(
    parameter int DEB_MAX = 1000000,
    parameter int DEB_W   = 20
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        ToMem,
    input  logic [5:0]  Addr,
    input  logic [15:0] Sw,
    input  logic        BtnLo,
    input  logic        BtnHi,
    input  logic        BtnWr,
    output logic [4:0]  WriteReg,
    output logic [5:0]  WriteMem,
    output logic [31:0] WData,
    output logic        RegWE,
    output logic        MemWE,
    output logic [31:0] Staged,
    output logic        Busy
);

    // Button index: 0 = Lo, 1 = Hi, 2 = Wr
    localparam int NB = 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        HOLD
    } state_t;

    logic [NB-1:0]    btn_raw;
    logic [NB-1:0]    sync1;
    logic [NB-1:0]    sync2;
    logic [NB-1:0]    level;
    logic [NB-1:0]    press;
    logic [DEB_W-1:0] cnt [NB];
    state_t           state;
    logic [5:0]       tgt;

    assign btn_raw = {BtnWr, BtnHi, BtnLo};

    // Synchronize, debounce and edge-detect all three buttons
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < NB; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] != level[i]) begin
                    // Level only flips after DEB_MAX+1 consecutive differing samples
                    if (cnt[i] == DEB_W'(DEB_MAX)) begin
                        level[i] <= sync2[i];
                        press[i] <= sync2[i];
                        cnt[i]   <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Assemble the staged word from the two switch halves
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            Staged <= '0;
        end else begin
            if (press[0]) begin
                Staged[15:0] <= Sw;
            end
            if (press[1]) begin
                Staged[31:16] <= Sw;
            end
        end
    end

`ifdef BOARD_ENTRY_AUTO_INC_EN
    logic [5:0] ptr;
    logic [5:0] addr_q;
    logic       to_mem_q;

    assign tgt = ptr;

    // Address pointer: follows Addr when it moves, otherwise advances after each write
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ptr    <= '0;
            addr_q <= '0;
        end else begin
            addr_q <= Addr;
            if (Addr != addr_q) begin
                ptr <= Addr;
            end else if (state == WRITE) begin
                ptr <= to_mem_q ? ptr + 6'd1 : {1'b0, ptr[4:0] + 5'd1};
            end
        end
    end

    // Remember the target space chosen at commit for the pointer wrap
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            to_mem_q <= 1'b0;
        end else if (state == IDLE && press[2]) begin
            to_mem_q <= ToMem;
        end
    end
`else
    assign tgt = Addr;
`endif

    // Commit sequencer: one strobe per accepted press, then wait for release
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            WData    <= '0;
            WriteReg <= '0;
            WriteMem <= '0;
            RegWE    <= 1'b0;
            MemWE    <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (press[2]) begin
                        state <= WRITE;
                        WData <= Staged;
                        Busy  <= 1'b1;
                        if (ToMem) begin
                            WriteMem <= tgt;
                            WriteReg <= 5'd0;
                            MemWE    <= 1'b1;
                        end else begin
                            WriteReg <= tgt[4:0];
                            WriteMem <= 6'd0;
                            // $zero is read-only; sequence anyway so Busy still pulses
                            RegWE    <= (tgt[4:0] != 5'd0);
                        end
                    end
                end
                WRITE: begin
                    RegWE <= 1'b0;
                    MemWE <= 1'b0;
                    state <= HOLD;
                end
                HOLD: begin
                    if (!level[2]) begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    RegWE <= 1'b0;
                    MemWE <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_entry.sv
// tb/tb_board_entry.sv - directed self-checking bench for board_entry
module tb_board_entry;

    localparam int DM = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        ToMem = 1'b0;
    logic [5:0]  Addr = '0;
    logic [15:0] Sw = '0;
    logic        BtnLo = 1'b0;
    logic        BtnHi = 1'b0;
    logic        BtnWr = 1'b0;
    logic [4:0]  WriteReg;
    logic [5:0]  WriteMem;
    logic [31:0] WData;
    logic        RegWE;
    logic        MemWE;
    logic [31:0] Staged;
    logic        Busy;

    int errors = 0;
    int checks = 0;
    int reg_we_n = 0;
    int mem_we_n = 0;
    int busy_n = 0;
    logic [5:0] last_mem = '0;
    logic [4:0] last_reg = '0;

    board_entry #(.DEB_MAX(DM), .DEB_W(4)) dut (
        .clk(clk), .clr(clr), .ToMem(ToMem), .Addr(Addr), .Sw(Sw),
        .BtnLo(BtnLo), .BtnHi(BtnHi), .BtnWr(BtnWr),
        .WriteReg(WriteReg), .WriteMem(WriteMem), .WData(WData),
        .RegWE(RegWE), .MemWE(MemWE), .Staged(Staged), .Busy(Busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (RegWE) begin
            reg_we_n = reg_we_n + 1;
            last_reg = WriteReg;
        end
        if (MemWE) begin
            mem_we_n = mem_we_n + 1;
            last_mem = WriteMem;
        end
        if (Busy) busy_n = busy_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        reg_we_n = 0;
        mem_we_n = 0;
        busy_n   = 0;
    endtask

    task automatic press_wr(input int hold);
        BtnWr = 1'b1;
        step(hold);
        BtnWr = 1'b0;
        step(DM + 6);
    endtask

    initial begin
        step(2);
        chk("rst_staged", Staged, 32'h0);
        chk("rst_wdata", WData, 32'h0);
        chk("rst_busy", {31'b0, Busy}, 32'h0);
        chk("rst_we", {30'b0, RegWE, MemWE}, 32'h0);
        clr = 1'b1;
        step(2);

        // Low half
        Sw = 16'h1234;
        BtnLo = 1'b1;
        step(DM + 3);
        chk("lo_early", Staged, 32'h0);
        step(1);
        chk("lo_load", Staged, 32'h0000_1234);
        BtnLo = 1'b0;
        step(DM + 6);

        // High half
        Sw = 16'hABCD;
        BtnHi = 1'b1;
        step(DM + 3);
        chk("hi_early", Staged, 32'h0000_1234);
        step(1);
        chk("hi_load", Staged, 32'hABCD_1234);
        BtnHi = 1'b0;
        step(DM + 6);

        // Register write, button held 50 cycles
        ToMem = 1'b0;
        Addr = 6'd5;
        step(2);
        clear_counts();
        BtnWr = 1'b1;
        step(DM + 3);
        chk("reg_we_early", {31'b0, RegWE}, 32'h0);
        step(1);
        chk("reg_we_lat", {31'b0, RegWE}, 32'h1);
        chk("reg_addr", {27'b0, WriteReg}, 32'd5);
        chk("reg_data", WData, 32'hABCD_1234);
        step(50 - (DM + 4));
        chk("busy_held", {31'b0, Busy}, 32'h1);
        BtnWr = 1'b0;
        step(DM + 3);
        chk("busy_pre_rel", {31'b0, Busy}, 32'h1);
        step(1);
        chk("busy_rel", {31'b0, Busy}, 32'h0);
        chk("reg_we_count", reg_we_n, 32'd1);
        chk("reg_mem_we_count", mem_we_n, 32'd0);
        step(4);

        // Memory write at top address
        ToMem = 1'b1;
        Addr = 6'd63;
        step(2);
        clear_counts();
        press_wr(20);
        chk("mem_we_count", mem_we_n, 32'd1);
        chk("mem_reg_we_count", reg_we_n, 32'd0);
        chk("mem_addr", {26'b0, last_mem}, 32'd63);
        chk("mem_writereg", {27'b0, WriteReg}, 32'd0);
        chk("mem_wdata_hold", WData, 32'hABCD_1234);

        // Register 0 is suppressed but sequences
        ToMem = 1'b0;
        Addr = 6'd0;
        step(2);
        clear_counts();
        press_wr(20);
        chk("zero_busy_cycles", busy_n, 32'd20);
        chk("zero_reg_we", reg_we_n, 32'd0);
        chk("zero_mem_we", mem_we_n, 32'd0);

        // Short glitches
        Addr = 6'd9;
        step(2);
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            BtnWr = 1'b1;
            step(2);
            BtnWr = 1'b0;
            step(2);
        end
        step(10);
        chk("glitch_we", reg_we_n + mem_we_n, 32'd0);
        chk("glitch_busy", busy_n, 32'd0);

        // Reset in the middle of WRITE
        Addr = 6'd7;
        step(2);
        BtnWr = 1'b1;
        step(DM + 4);
        chk("abort_we_pre", {31'b0, RegWE}, 32'h1);
        clr = 1'b0;
        #1;
        chk("abort_we", {30'b0, RegWE, MemWE}, 32'h0);
        chk("abort_busy", {31'b0, Busy}, 32'h0);
        chk("abort_staged", Staged, 32'h0);
        chk("abort_wdata", WData, 32'h0);
        chk("abort_addr", {21'b0, WriteReg, WriteMem}, 32'h0);
        BtnWr = 1'b0;
        step(3);
        clr = 1'b1;
        clear_counts();
        step(20);
        chk("abort_no_write", reg_we_n + mem_we_n, 32'd0);
        chk("abort_no_busy", busy_n, 32'd0);

`ifdef BOARD_ENTRY_AUTO_INC_EN
        ToMem = 1'b1;
        Addr = 6'd62;
        step(2);
        clear_counts();
        press_wr(12);
        chk("inc_first", {26'b0, last_mem}, 32'd62);
        press_wr(12);
        chk("inc_second", {26'b0, last_mem}, 32'd63);
        press_wr(12);
        chk("inc_wrap", {26'b0, last_mem}, 32'd0);
        Addr = 6'd10;
        step(2);
        press_wr(12);
        chk("inc_reload", {26'b0, last_mem}, 32'd10);
        chk("inc_count", mem_we_n, 32'd4);
`else
        ToMem = 1'b1;
        Addr = 6'd62;
        step(2);
        clear_counts();
        press_wr(12);
        chk("fixed_first", {26'b0, last_mem}, 32'd62);
        press_wr(12);
        chk("fixed_second", {26'b0, last_mem}, 32'd62);
        chk("fixed_count", mem_we_n, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/board_entry.md
Name: board_entry

Overview:
- Front-panel data-entry block. It is the write-side counterpart of the 7-segment display path: it takes board switches and push-buttons and writes one 32-bit word into the MIPS register file or data memory.
- It assembles the word from two 16-bit switch halves, then issues a single-cycle write strobe to the addressed register or memory word.
- It exposes the staged word so the display path can show it before it is committed.

Parameters:
- DEB_MAX, 1000000, stable-sample count before a button edge is accepted (10 ms at 100 MHz; benches use 4).
- DEB_W, 20, width of the debounce counter; must satisfy 2^DEB_W > DEB_MAX.

Ports:
- clk  in  1  system clock
- clr  in  1  reset, asynchronous, active-low
- ToMem  in  1  0: target register file; 1: target data memory
- Addr  in  6  target address; register mode uses Addr[4:0]
- Sw  in  16  switch value
- BtnLo  in  1  raw button: latch Sw into Staged[15:0]
- BtnHi  in  1  raw button: latch Sw into Staged[31:16]
- BtnWr  in  1  raw button: commit Staged
- WriteReg  out  5  register write address
- WriteMem  out  6  memory write address
- WData  out  32  write data
- RegWE  out  1  register-file write enable, one-cycle pulse
- MemWE  out  1  memory write enable, one-cycle pulse
- Staged  out  32  word being assembled
- Busy  out  1  high from WRITE until BtnWr is released

Behaviour:
- Reset (clr=0, asynchronous):
  - Staged, WData, WriteReg, WriteMem, RegWE, MemWE, Busy all go to 0.
  - Debounce counters clear, synchronizers clear, FSM enters IDLE.
  - Reset mid-write aborts the write; no strobe follows reset release.
- Button input chain:
  - Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debounce counter increments while the synced value differs from the accepted level and clears otherwise.
  - At DEB_MAX the accepted level toggles and the counter clears.
  - A one-cycle press pulse fires on an accepted 0->1 transition.
  - Latency from a raw clean edge to the press pulse is DEB_MAX+3 cycles.
  - Glitches shorter than DEB_MAX cycles produce no pulse.
- Staging:
  - A Lo pulse loads Staged[15:0]<=Sw on the next edge; a Hi pulse loads Staged[31:16]<=Sw.
  - Simultaneous Lo and Hi pulses update both halves.
  - Staging is accepted in every FSM state.
- FSM states: IDLE, WRITE, HOLD.
  - IDLE -> WRITE on a Wr pulse. On the same edge:
    - WData<=Staged.
    - WriteReg<=Addr[4:0] and WriteMem<=6'b0 when ToMem=0.
    - WriteMem<=Addr and WriteReg<=5'b0 when ToMem=1.
  - WRITE, exactly 1 cycle:
    - RegWE=~ToMem and MemWE=ToMem, using ToMem as latched at entry.
    - RegWE is suppressed when the register address is 0 ($zero is not writable). The FSM still sequences.
    - Busy=1.
    - Then go to HOLD.
  - HOLD: Busy=1; stay until the debounced BtnWr level is 0, then go to IDLE.
    - One press gives exactly one write; holding the button never repeats the write.
  - Staging pulses coinciding with the IDLE->WRITE edge do not alter the committed WData; they affect Staged only.
  - WData and addresses hold their values after the write until the next commit.
- Total latency from the accepted Wr pulse to the WE pulse is 1 cycle.

Optional Feature:
- Macro: BOARD_ENTRY_AUTO_INC_EN.
- Defined:
  - An internal 6-bit pointer Ptr is reset to 0.
  - Ptr reloads from Addr whenever Addr differs from its registered copy from the previous cycle.
  - WRITE uses Ptr instead of Addr. Register mode uses Ptr[4:0], so Ptr 0 is still suppressed.
  - Ptr increments on exit from WRITE: register mode wraps 31->0, memory mode wraps 63->0.
  - Successive presses fill consecutive words without moving Addr.
- Undefined: no Ptr logic is present; the address is always Addr sampled at the WRITE entry edge.

Test Plan (DEB_MAX=4):
- Sw=16'h1234 with a BtnLo press, then Sw=16'hABCD with a BtnHi press: Staged=32'hABCD1234. Neither pulse fires before DEB_MAX+3 cycles.
- Then ToMem=0, Addr=6'd5, BtnWr held 50 cycles:
  - Exactly one RegWE pulse with WriteReg=5, WData=32'hABCD1234; MemWE stays 0.
  - Busy stays high until release is debounced.
- ToMem=1, Addr=6'd63, BtnWr press: one MemWE pulse with WriteMem=63; RegWE stays 0.
- ToMem=0, Addr=0, BtnWr press: Busy pulses through WRITE/HOLD, but RegWE and MemWE both stay 0.
- BtnWr toggling with 2-cycle glitches: no WE pulse. Assert clr=0 during WRITE: all outputs drop to 0 immediately, and there is no write after release.
- With BOARD_ENTRY_AUTO_INC_EN, ToMem=1, Addr=62, three presses: writes land at addresses 62, 63, 0. Changing Addr to 10 makes the next write land at 10.
